// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage
//   Fetch-to-decode pipeline stage. Registers each instruction/PC accepted
//   from the ICACHE behind a valid/ready handshake. A second (skid) register
//   absorbs one extra word when decode stalls, so the stage sustains one word
//   per cycle. The immediate-source code and the immediate field are
//   pre-decoded on entry and stored with the word. This lets the immediate
//   extender be driven straight from registers.
//
//   Optional feature: define IFID_ILLEGAL_DETECT_EN to flag unknown opcodes on
//   id_illegal. The flag travels with the word through skid and main. When
//   the macro is undefined, id_illegal is tied to 0.
//
// Ports
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   flush        : redirect; drops main and skid contents and any same-cycle word
//   ic_valid     : ICACHE response handshake (input)
//   ic_ready     : ICACHE response handshake (output, registered, == !skid_valid)
//   ic_instr     : instruction word from the ICACHE
//   ic_pc        : PC of ic_instr
//   id_valid     : decode handshake (output)
//   id_ready     : decode handshake (input)
//   id_instr     : buffered instruction to decode
//   id_pc        : buffered PC to decode
//   id_imm_src   : immediate-source code for the extender
//   id_imm_data  : id_instr[31:7]
//   id_illegal   : unknown-opcode flag (0 unless IFID_ILLEGAL_DETECT_EN)
module if_id_skid_stage #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ic_valid,
  input  logic [XLEN-1:0] ic_instr,
  input  logic [XLEN-1:0] ic_pc,
  output logic            ic_ready,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [2:0]      id_imm_src,
  output logic [24:0]     id_imm_data,
  output logic            id_illegal
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [2:0]      skid_imm_src;
  logic [24:0]     skid_imm_data;

  logic [2:0]      in_imm_src;
  logic [24:0]     in_imm_data;

  logic accept;
  logic main_free;
  logic main_from_skid;
  logic main_from_in;
  logic skid_load;
  logic skid_valid_nxt;

  // Main can take a word when it is empty or its word is consumed this cycle.
  assign accept         = ic_valid & ic_ready;
  assign main_free      = ~id_valid | id_ready;
  // Skid is always older than the incoming word, so it drains first.
  assign main_from_skid = main_free & skid_valid;
  assign main_from_in   = main_free & ~skid_valid & accept;
  assign skid_load      = accept & (~main_free | skid_valid);

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (skid_load)
      skid_valid_nxt = 1'b1;
    else if (main_from_skid)
      skid_valid_nxt = 1'b0;
  end

  // Immediate-source pre-decode of the incoming word.
  always_comb begin
    in_imm_src = 3'b000;
    case (ic_instr[6:0])
      7'b0000011: in_imm_src = 3'b111;
      7'b0010011: begin
        case (ic_instr[14:12])
          3'b001:  in_imm_src = 3'b110;
          3'b101:  in_imm_src = ic_instr[30] ? 3'b101 : 3'b110;
          default: in_imm_src = 3'b000;
        endcase
      end
      7'b0100011: in_imm_src = 3'b001;
      7'b1100011: in_imm_src = 3'b010;
      7'b1101111: in_imm_src = 3'b011;
      7'b0110111,
      7'b0010111: in_imm_src = 3'b100;
      default:    in_imm_src = 3'b000;
    endcase
  end

  assign in_imm_data = ic_instr[31:7];

  // Handshake state. ic_ready is registered from the next skid state so it
  // drops the cycle after skid fills.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
      ic_ready   <= 1'b1;
    end else begin
      if (main_free)
        id_valid <= skid_valid | accept;
      skid_valid <= skid_valid_nxt;
      ic_ready   <= ~skid_valid_nxt;
    end
  end

  // Payload registers hold their contents on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr      <= NOP;
      id_pc         <= RESET_PC;
      id_imm_src    <= 3'b000;
      id_imm_data   <= 25'h0;
      skid_instr    <= NOP;
      skid_pc       <= RESET_PC;
      skid_imm_src  <= 3'b000;
      skid_imm_data <= 25'h0;
    end else if (!flush) begin
      if (main_from_skid) begin
        id_instr    <= skid_instr;
        id_pc       <= skid_pc;
        id_imm_src  <= skid_imm_src;
        id_imm_data <= skid_imm_data;
      end else if (main_from_in) begin
        id_instr    <= ic_instr;
        id_pc       <= ic_pc;
        id_imm_src  <= in_imm_src;
        id_imm_data <= in_imm_data;
      end
      if (skid_load) begin
        skid_instr    <= ic_instr;
        skid_pc       <= ic_pc;
        skid_imm_src  <= in_imm_src;
        skid_imm_data <= in_imm_data;
      end
    end
  end

`ifdef IFID_ILLEGAL_DETECT_EN
  logic in_illegal;
  logic skid_illegal;

  // Every listed opcode ends in 2'b11, so a compressed encoding is also illegal.
  always_comb begin
    in_illegal = 1'b1;
    case (ic_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
      7'b0110011, 7'b1110011, 7'b0001111: in_illegal = 1'b0;
      default:                            in_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_illegal   <= 1'b0;
      skid_illegal <= 1'b0;
    end else if (!flush) begin
      if (main_from_skid)
        id_illegal <= skid_illegal;
      else if (main_from_in)
        id_illegal <= in_illegal;
      if (skid_load)
        skid_illegal <= in_illegal;
    end
  end
`else
  assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ic_valid;
  logic [31:0] ic_instr;
  logic [31:0] ic_pc;
  logic        ic_ready;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  id_imm_src;
  logic [24:0] id_imm_data;
  logic        id_illegal;

`ifdef IFID_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  if_id_skid_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ic_valid(ic_valid), .ic_instr(ic_instr), .ic_pc(ic_pc), .ic_ready(ic_ready),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_imm_src(id_imm_src), .id_imm_data(id_imm_data), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // Stimulus words with their expected immediate-source code and legality.
  localparam int LW = 0, SW = 1, SRAI = 2, SRLI = 3, JAL = 4, LUI = 5, ADDI = 6,
                 SLLI = 7, BEQ = 8, AUIPC = 9, JALR = 10, BAD = 11, ADD = 12, ZERO = 13;
  logic [31:0] tbl_instr [14] = '{32'h00412083, 32'h00112423, 32'h4032d293, 32'h0032d293,
                                  32'h0100006f, 32'h000010b7, 32'h00a00093, 32'h00309093,
                                  32'h00208463, 32'h00000117, 32'h000080e7, 32'h0000007f,
                                  32'h002081b3, 32'h00000000};
  logic [2:0]  tbl_src   [14] = '{3'b111, 3'b001, 3'b101, 3'b110, 3'b011, 3'b100, 3'b000,
                                  3'b110, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
  bit          tbl_bad   [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  src;
    bit          ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   last_acc;
  logic [2:0] cur_src;
  bit   cur_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int idx, input logic [31:0] pc);
    ic_valid = v;
    ic_instr = tbl_instr[idx];
    ic_pc    = pc;
    cur_src  = tbl_src[idx];
    cur_ill  = tbl_bad[idx] && ILL_EN;
  endtask

  // One clock: scoreboard compare on consume, record accept, then step past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, id_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_instr",    id_instr,             e.instr);
        check("out_pc",       id_pc,                e.pc);
        check("out_imm_src",  {29'b0, id_imm_src},  {29'b0, e.src});
        check("out_imm_data", {7'b0, id_imm_data},  {7'b0, e.instr[31:7]});
        check("out_illegal",  {31'b0, id_illegal},  {31'b0, e.ill});
      end
    end
    last_acc = ic_valid && ic_ready && !flush && !reset;
    if (last_acc) begin
      e.instr = ic_instr;
      e.pc    = ic_pc;
      e.src   = cur_src;
      e.ill   = cur_ill;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 20) begin
      tick();
      k++;
    end
    check("accept_timeout", {31'b0, last_acc}, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    id_ready = 1'b1;
    ic_valid = 1'b0;
    while ((exp_q.size() > 0 || id_valid) && k < 30) begin
      tick();
      k++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive(0, LW, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_id_valid", {31'b0, id_valid},  32'd0);
    check("rst_ic_ready", {31'b0, ic_ready},  32'd1);
    check("rst_id_instr", id_instr,           32'h0000_0013);
    check("rst_id_pc",    id_pc,              32'h0);
    check("rst_imm_src",  {29'b0, id_imm_src}, 32'd0);
    check("rst_imm_data", {7'b0, id_imm_data}, 32'd0);
    check("rst_illegal",  {31'b0, id_illegal}, 32'd0);

    // Back-to-back streaming with decode always ready.
    id_ready = 1'b1;
    drive(1, LW, 32'h0);  tick();
    drive(1, SW, 32'h4);
    check("lw_valid",    {31'b0, id_valid},    32'd1);
    check("lw_imm_src",  {29'b0, id_imm_src},  32'd7);
    check("lw_imm_data", {7'b0, id_imm_data},  32'h0008241); // lw x1,4(x2) bits [31:7]
    tick();
    drive(1, LUI, 32'h8);
    check("sw_valid",    {31'b0, id_valid},    32'd1);
    check("sw_imm_src",  {29'b0, id_imm_src},  32'd1);
    check("sw_ic_ready", {31'b0, ic_ready},    32'd1);
    tick();
    drive(0, LW, 32'h0);
    check("lui_valid",   {31'b0, id_valid},    32'd1);
    check("lui_imm_src", {29'b0, id_imm_src},  32'd4);
    drain();

    // Decode stall: main then skid fill, third word waits for ic_ready.
    id_ready = 1'b0;
    drive(1, SRAI, 32'h8);  tick();
    check("stall_rdy1", {31'b0, ic_ready}, 32'd1);
    drive(1, SRLI, 32'hc);  tick();
    check("stall_rdy2", {31'b0, ic_ready}, 32'd0);
    drive(1, JAL, 32'h10);  tick();
    check("stall_acc3",  {31'b0, last_acc}, 32'd0);
    check("stall_hold",  id_instr,          32'h4032d293);
    check("stall_src",   {29'b0, id_imm_src}, 32'd5);
    id_ready = 1'b1;
    wait_accept();
    drive(0, LW, 32'h0);
    drain();

    // Flush with main and skid full; concurrent word must vanish.
    id_ready = 1'b0;
    drive(1, ADDI, 32'h20);  tick();
    drive(1, BEQ,  32'h24);  tick();
    drive(1, SLLI, 32'h28);  flush = 1'b1;  tick();
    flush = 1'b0;  drive(0, LW, 32'h0);
    check("flush_valid", {31'b0, id_valid}, 32'd0);
    check("flush_ready", {31'b0, ic_ready}, 32'd1);
    check("flush_hold",  id_instr,          32'h00a00093);
    exp_q.delete();
    id_ready = 1'b1;
    repeat (3) tick();

    // Flush with only main full (ic_ready high) plus a same-cycle word.
    id_ready = 1'b0;
    drive(1, AUIPC, 32'h30);  tick();
    drive(1, JALR,  32'h34);  flush = 1'b1;  tick();
    flush = 1'b0;  drive(0, LW, 32'h0);
    check("flush2_valid", {31'b0, id_valid}, 32'd0);
    exp_q.delete();
    id_ready = 1'b1;
    repeat (3) tick();

    // Unknown opcode.
    drive(1, BAD, 32'h40);  tick();
    drive(0, LW, 32'h0);
    check("bad_valid",   {31'b0, id_valid},   32'd1);
    check("bad_illegal", {31'b0, id_illegal}, {31'b0, ILL_EN});
    drain();

    // Reset in the middle of a stall.
    id_ready = 1'b0;
    drive(1, ADD, 32'h50);  tick();
    drive(1, SW,  32'h54);  tick();
    drive(0, LW, 32'h0);  reset = 1'b1;  tick();
    reset = 1'b0;
    exp_q.delete();
    check("mrst_valid", {31'b0, id_valid}, 32'd0);
    check("mrst_ready", {31'b0, ic_ready}, 32'd1);
    check("mrst_instr", id_instr,          32'h0000_0013);
    check("mrst_src",   {29'b0, id_imm_src}, 32'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 13)), 32'h1000 + 32'(i * 4));
      tick();
      if (i % 20 == 0)
        check("rand_ready", {31'b0, ic_ready}, {31'b0, !(id_valid && exp_q.size() >= 2)});
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
